// File: rtl/rc5_scan_pkg.sv
// Shared constants for the RC5 scan-chain master: chain lengths, field positions
// inside the stimulus/result vectors, and the sequencer state encoding.
package rc5_scan_pkg;

  localparam int IN_BITS  = 168;
  localparam int OUT_BITS = 33;

  localparam int KEY_LSB     = 0;
  localparam int DIN_LSB     = 128;
  localparam int NR_LSB      = 160;
  localparam int LOADKEY_BIT = 165;
  localparam int ENC_BIT     = 166;
  localparam int DEC_BIT     = 167;
  localparam int DONE_BIT    = 32;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SHIFT_IN  = 3'd1,
    S_HOLD      = 3'd2,
    S_SHIFT_OUT = 3'd3,
    S_DONE      = 3'd4
  } scan_state_t;

endpackage

// File: rtl/rc5_scan_master.sv
// Drives one shift-in / validate-hold / shift-out sequence on the rc5 scan port.
// Every output is decoded from registered state, so inputs never reach outputs combinationally.
module rc5_scan_master
  import rc5_scan_pkg::*;
#(
  parameter int WAIT_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [IN_BITS-1:0]  in_vec,
  input  logic [WAIT_W-1:0]   wait_cycles,
  output logic                busy,
  output logic                done,
  output logic [OUT_BITS-1:0] out_vec,
  output logic                scan_en,
  output logic                scan_in,
  output logic                begin_validate,
  input  logic                scan_out
);

  localparam logic [7:0] IN_LAST  = 8'(IN_BITS - 1);
  localparam logic [7:0] OUT_LAST = 8'(OUT_BITS - 1);

  scan_state_t        state;
  logic [7:0]         cnt;
  logic [WAIT_W-1:0]  hcnt;
  logic [WAIT_W-1:0]  weff;
  logic [IN_BITS-1:0] sreg_in;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      hcnt    <= '0;
      weff    <= '0;
      sreg_in <= '0;
      out_vec <= '0;
    end else if (abort && state != S_IDLE) begin
      state <= S_IDLE;
      cnt   <= '0;
      hcnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            sreg_in <= in_vec;
            // a zero hold would skip the validate window entirely; treat it as one cycle
            weff    <= (wait_cycles == '0) ? WAIT_W'(1) : wait_cycles;
            cnt     <= '0;
            hcnt    <= '0;
            state   <= S_SHIFT_IN;
          end
        end
        S_SHIFT_IN: begin
          sreg_in <= {sreg_in[IN_BITS-2:0], 1'b0};
          if (cnt == IN_LAST) begin
            cnt   <= '0;
            state <= S_HOLD;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_HOLD: begin
          if (hcnt == weff - 1'b1) begin
            hcnt  <= '0;
            cnt   <= '0;
            state <= S_SHIFT_OUT;
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end
        S_SHIFT_OUT: begin
          out_vec <= {out_vec[OUT_BITS-2:0], scan_out};
          if (cnt == OUT_LAST) begin
            cnt   <= '0;
            state <= S_DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy           = (state != S_IDLE);
  assign done           = (state == S_DONE);
  assign scan_en        = (state == S_SHIFT_IN) || (state == S_SHIFT_OUT);
  assign scan_in        = (state == S_SHIFT_IN) && sreg_in[DEC_BIT];
  assign begin_validate = (state == S_HOLD) || (state == S_SHIFT_OUT);

endmodule

// File: doc/rc5_scan_master.md
Name: rc5_scan_master

Overview:
- Scan-chain controller that drives the RC5 accelerator's validation port (scan_en, scan_in, begin_validate) and captures its scan_out.
- Accepts a 168-bit stimulus vector and a wait count from a test sequencer or host.
- Runs one full scan-validate sequence: shift in, hold in validate mode, shift out.
- Returns the 33-bit captured result {done, d_out}. Sits between the on-chip test controller and rc5.

Parameters:
- IN_BITS, 168, scan-in chain length: {start_decrypt, start_encrypt, load_key, num_rounds[4:0], d_in[31:0], key[127:0]}.
- OUT_BITS, 33, scan-out chain length: {done, d_out[31:0]}.
- WAIT_W, 16, width of the validate-hold counter.

Ports:
- clk  in  1  clock
- reset  in  1  reset; asynchronous, active-high
- start  in  1  begin a sequence; sampled only in IDLE
- abort  in  1  synchronous abort of an active sequence
- in_vec  in  IN_BITS  stimulus; bit 167 is start_decrypt, bit 0 is key[0]
- wait_cycles  in  WAIT_W  validate-hold length in cycles, latched at start
- busy  out  1  high when state is not IDLE
- done  out  1  one-cycle pulse; out_vec is valid
- out_vec  out  OUT_BITS  captured result; bit 32 is done, [31:0] is d_out
- scan_en  out  1  to rc5 scan_en
- scan_in  out  1  to rc5 scan_in
- begin_validate  out  1  to rc5 begin_validate
- scan_out  in  1  from rc5 scan_out

Behaviour:
- Clock is clk. Reset is reset: asynchronous, active-high.
- Reset values: state IDLE, all counters 0, out_vec 0, busy/done/scan_en/scan_in/begin_validate all 0.
- All outputs are decoded from flops only, so there are no combinational paths from inputs to outputs.
- States: IDLE, SHIFT_IN, HOLD, SHIFT_OUT, DONE.
- IDLE, on start=1:
  - latch in_vec into sreg_in;
  - latch weff = (wait_cycles==0) ? 1 : wait_cycles;
  - clear bit counter; go to SHIFT_IN.
- SHIFT_IN (exactly IN_BITS cycles):
  - scan_en=1, scan_in=sreg_in[167], begin_validate=0;
  - each edge: sreg_in <<= 1, cnt++;
  - at cnt==IN_BITS-1 go to HOLD.
  - The MSB goes out first, so rc5's chain holds in_vec exactly after the last edge.
- HOLD (exactly weff cycles):
  - scan_en=0, scan_in=0, begin_validate=1;
  - hold counter counts up to weff, then go to SHIFT_OUT with cnt cleared.
- SHIFT_OUT (exactly OUT_BITS cycles):
  - scan_en=1, scan_in=0, begin_validate=1;
  - each edge: out_vec <= {out_vec[31:0], scan_out}, cnt++;
  - at cnt==OUT_BITS-1 go to DONE.
  - The first bit captured is rc5 bit 32, so it lands in out_vec[32].
- DONE (1 cycle): begin_validate=0, scan_en=0, done=1; next state IDLE.
- out_vec holds its value until the next SHIFT_OUT. It is not cleared at start.
- Latency: start sampled at edge E gives done high in the cycle following edge E+201+weff. busy rises at E and falls at E+202+weff.
- start while busy: ignored; no queuing.
- abort=1 in any non-IDLE state: next edge forces IDLE, begin_validate=0, scan_en=0, no done pulse, out_vec unchanged.
- abort takes priority over all state transitions. abort together with start in IDLE: start wins, because abort only affects active states.
- reset mid-sequence: outputs go to 0 immediately (async); a new start is required.
- Counter widths: bit counter 8 bits (max 167); hold counter WAIT_W bits. wait_cycles=0xFFFF is legal (65535-cycle hold); no wrap.

Decomposition:
- Package rc5_scan_pkg holds:
  - IN_BITS=168, OUT_BITS=33;
  - field LSB constants: KEY_LSB=0, DIN_LSB=128, NR_LSB=160, LOADKEY_BIT=165, ENC_BIT=166, DEC_BIT=167, DONE_BIT=32;
  - state enum scan_state_t.
- Single module. No sub-module: the shift registers and counters are too small to warrant one.

Test Plan:
- Chain model: bench model of rc5's chain that shifts in on scan_en, and on begin_validate rise loads output reg = 33'h1_DEADBEEF, MSB out first. Stimulus: in_vec = {1'b0,1'b1,1'b0,5'd12,32'h01234567,128'h0F0E0D0C_0B0A0908_07060504_03020100}, wait=10. Required: model captures in_vec exactly; out_vec=33'h1_DEADBEEF; done at E+211.
- Cycle counts: scan_en high for exactly 168 cycles, low for 10, high for 33. begin_validate high for exactly 43 cycles and never overlaps SHIFT_IN.
- wait_cycles=0 behaves identically to wait_cycles=1: HOLD is 1 cycle, done at E+202.
- start pulsed at E+5 while busy is ignored: no restart, single done pulse. A back-to-back start in the cycle after done is accepted.
- abort at E+100 (mid SHIFT_IN): IDLE next edge, no done, out_vec keeps its previous value 33'h1_DEADBEEF. abort during HOLD drops begin_validate the next cycle.
- reset asserted during SHIFT_OUT: all outputs 0 asynchronously. After release, a fresh sequence with model value 33'h0_00000000 yields out_vec=0 and a done pulse.
